hdlc_rx_monitor: RTL and testbench

HDLC_RX_MONITOR -- requirements
Module: hdlc_rx_monitor

---
 rtl/hdlc_rx_monitor.sv | 152 +++++++++++++++
 tb/tb_hdlc_rx_monitor.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_rx_monitor.sv
// Passive checker for an HDLC receiver. It rebuilds flag, abort, end-of-frame and overflow
// expectations from the serial line and the frame strobes, then reports any disagreement.
module hdlc_rx_monitor #(
  parameter int FLAG_LAT  = 2,
  parameter int ABORT_LAT = 2,
  parameter int MAX_BYTES = 128,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 MonEn,
  input  logic                 ErrClr,
  input  logic                 Rx,
  input  logic                 Rx_ValidFrame,
  input  logic                 Rx_FlagDetect,
  input  logic                 Rx_AbortDetect,
  input  logic                 Rx_AbortSignal,
  input  logic                 Rx_EoF,
  input  logic                 Rx_NewByte,
  input  logic                 Rx_Overflow,
  output logic [4:0]           ErrVec,
  output logic                 ErrPulse,
  output logic [ERR_CNT_W-1:0] ErrCnt,
  output logic [15:0]          FrameCnt
);

  localparam int              BC_W      = $clog2(MAX_BYTES + 2);
  localparam logic [BC_W-1:0] BC_MAX    = BC_W'(MAX_BYTES);
  localparam logic [BC_W-1:0] BC_SAT    = BC_W'(MAX_BYTES + 1);
  localparam logic [7:0]      FLAG_PAT  = 8'b0111_1110;
  localparam logic [7:0]      ABORT_PAT = 8'b0111_1111;

  // history_q holds the seven previous Rx bits; with the current Rx it forms the 8-bit window.
  logic [6:0]           history_q, history_d;
  logic [7:0]           hist_win;
  logic [6:0]           vf_hist_q, vf_hist_d;
  logic                 ovf_prev_q, ovf_prev_d;
  logic [2:0]           warm_q, warm_d;
  logic [FLAG_LAT-1:0]  flag_dl_q, flag_dl_d;
  logic [ABORT_LAT-1:0] abort_dl_q, abort_dl_d;
  logic                 as_pend_q, as_pend_d;
  logic                 eof_pend_q, eof_pend_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic [BC_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [4:0]           err_vec_q, err_vec_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;

  logic                 hist_ok, edge_ok;
  logic                 vf_rise, vf_fall, ovf_rise;
  logic                 flag_push, abort_push;
  logic                 byte_inc, ovf_step;
  logic [4:0]           viol;
  logic [2:0]           viol_num;
  logic [ERR_CNT_W+2:0] cnt_sum;

  // NOTE: every signal written here gets a value on every path, so no latch can be inferred.
  always_comb begin
    hist_win  = {history_q, Rx};
    history_d = hist_win[6:0];
    vf_hist_d = {vf_hist_q[5:0], Rx_ValidFrame};
    ovf_prev_d = Rx_Overflow;
    warm_d    = (warm_q == 3'd7) ? warm_q : warm_q + 3'd1;

    // Past-value checks wait until their history holds real post-reset samples.
    hist_ok  = (warm_q == 3'd7);
    edge_ok  = (warm_q != 3'd0);
    vf_rise  = edge_ok && !vf_hist_q[0] && Rx_ValidFrame;
    vf_fall  = edge_ok && vf_hist_q[0] && !Rx_ValidFrame;
    ovf_rise = edge_ok && !ovf_prev_q && Rx_Overflow;

    flag_push  = MonEn && hist_ok && (hist_win == FLAG_PAT);
    abort_push = MonEn && hist_ok && (hist_win == ABORT_PAT) && (vf_hist_q == '0);
    flag_dl_d  = FLAG_LAT'({flag_dl_q, flag_push});
    abort_dl_d = ABORT_LAT'({abort_dl_q, abort_push});

    // A byte arriving on the opening cycle of a frame is the first byte of that frame.
    byte_inc = Rx_ValidFrame && Rx_NewByte && (byte_cnt_q != BC_SAT);
    ovf_step = !vf_rise && byte_inc && (byte_cnt_q == BC_MAX);
    if (vf_rise)       byte_cnt_d = Rx_NewByte ? BC_W'(1) : '0;
    else if (byte_inc) byte_cnt_d = byte_cnt_q + BC_W'(1);
    else               byte_cnt_d = byte_cnt_q;

    as_pend_d  = MonEn && Rx_ValidFrame && Rx_AbortDetect;
    eof_pend_d = MonEn && vf_fall;
    ovf_pend_d = MonEn && ovf_step;

    viol[0] = MonEn && (flag_dl_q[FLAG_LAT-1] != Rx_FlagDetect);
    viol[1] = MonEn && abort_dl_q[ABORT_LAT-1] && !Rx_AbortDetect;
    viol[2] = MonEn && as_pend_q && !Rx_AbortSignal;
    viol[3] = MonEn && eof_pend_q && !Rx_EoF;
    viol[4] = MonEn && ((ovf_pend_q && !Rx_Overflow) ||
                        (ovf_rise && (byte_cnt_q <= BC_MAX)));

    viol_num = {2'b00, viol[0]} + {2'b00, viol[1]} + {2'b00, viol[2]}
             + {2'b00, viol[3]} + {2'b00, viol[4]};
    cnt_sum  = {3'b000, err_cnt_q} + {{ERR_CNT_W{1'b0}}, viol_num};

    err_pulse_d = |viol;
    if (ErrClr) begin
      err_vec_d = '0;
      err_cnt_d = '0;
    end else begin
      err_vec_d = err_vec_q | viol;
      err_cnt_d = (|cnt_sum[ERR_CNT_W+2:ERR_CNT_W]) ? '1 : cnt_sum[ERR_CNT_W-1:0];
    end

    frame_cnt_d = frame_cnt_q + 16'(vf_fall);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      history_q   <= '0;
      vf_hist_q   <= '0;
      ovf_prev_q  <= 1'b0;
      warm_q      <= '0;
      flag_dl_q   <= '0;
      abort_dl_q  <= '0;
      as_pend_q   <= 1'b0;
      eof_pend_q  <= 1'b0;
      ovf_pend_q  <= 1'b0;
      byte_cnt_q  <= '0;
      err_vec_q   <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      history_q   <= history_d;
      vf_hist_q   <= vf_hist_d;
      ovf_prev_q  <= ovf_prev_d;
      warm_q      <= warm_d;
      flag_dl_q   <= flag_dl_d;
      abort_dl_q  <= abort_dl_d;
      as_pend_q   <= as_pend_d;
      eof_pend_q  <= eof_pend_d;
      ovf_pend_q  <= ovf_pend_d;
      byte_cnt_q  <= byte_cnt_d;
      err_vec_q   <= err_vec_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign ErrVec   = err_vec_q;
  assign ErrPulse = err_pulse_q;
  assign ErrCnt   = err_cnt_q;
  assign FrameCnt = frame_cnt_q;

endmodule

// File: tb/tb_hdlc_rx_monitor.sv
// Directed bench for hdlc_rx_monitor: a table of flag/abort latency cases plus hand-written
// frame sequences for end-of-frame, overflow, counter saturation, clear priority and reset.
module tb_hdlc_rx_monitor;

  logic        Clk = 1'b0;
  logic        Rst, MonEn, ErrClr, Rx;
  logic        Rx_ValidFrame, Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal;
  logic        Rx_EoF, Rx_NewByte, Rx_Overflow;
  logic [4:0]  ErrVec, ErrVec_s;
  logic        ErrPulse, ErrPulse_s;
  logic [15:0] ErrCnt;
  logic [2:0]  ErrCnt_s;
  logic [15:0] FrameCnt, FrameCnt_s;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int frames_exp = 0;

  hdlc_rx_monitor u_dut (
    .Clk(Clk), .Rst(Rst), .MonEn(MonEn), .ErrClr(ErrClr), .Rx(Rx),
    .Rx_ValidFrame(Rx_ValidFrame), .Rx_FlagDetect(Rx_FlagDetect),
    .Rx_AbortDetect(Rx_AbortDetect), .Rx_AbortSignal(Rx_AbortSignal),
    .Rx_EoF(Rx_EoF), .Rx_NewByte(Rx_NewByte), .Rx_Overflow(Rx_Overflow),
    .ErrVec(ErrVec), .ErrPulse(ErrPulse), .ErrCnt(ErrCnt), .FrameCnt(FrameCnt)
  );

  hdlc_rx_monitor #(.ERR_CNT_W(3)) u_dut_sat (
    .Clk(Clk), .Rst(Rst), .MonEn(MonEn), .ErrClr(ErrClr), .Rx(Rx),
    .Rx_ValidFrame(Rx_ValidFrame), .Rx_FlagDetect(Rx_FlagDetect),
    .Rx_AbortDetect(Rx_AbortDetect), .Rx_AbortSignal(Rx_AbortSignal),
    .Rx_EoF(Rx_EoF), .Rx_NewByte(Rx_NewByte), .Rx_Overflow(Rx_Overflow),
    .ErrVec(ErrVec_s), .ErrPulse(ErrPulse_s), .ErrCnt(ErrCnt_s), .FrameCnt(FrameCnt_s)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit         is_abort;
    bit         mon_en;
    int         det_delay;  // cycles after the last pattern bit; 0 = never asserted
    logic [4:0] exp_vec;
    int         exp_cnt;
    int         exp_pulses;
  } scen_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    if (ErrPulse) pulses++;
  endtask

  task automatic clear_errs();
    ErrClr = 1'b1;
    tick();
    ErrClr = 1'b0;
    pulses = 0;
  endtask

  task automatic send_pat(input logic [7:0] pat);
    for (int i = 7; i >= 0; i--) begin
      Rx = pat[i];
      tick();
    end
    Rx = 1'b0;
  endtask

  task automatic start_frame();
    Rx_ValidFrame = 1'b1;
    tick();
  endtask

  task automatic end_frame(input bit with_eof);
    Rx_ValidFrame = 1'b0;
    tick();
    Rx_EoF = with_eof;
    tick();
    Rx_EoF = 1'b0;
    frames_exp++;
  endtask

  task automatic send_bytes(input int n);
    Rx_NewByte = 1'b1;
    repeat (n) tick();
    Rx_NewByte = 1'b0;
  endtask

  task automatic run_scen(input int idx, input scen_t s);
    MonEn = s.mon_en;
    clear_errs();
    repeat (10) tick();
    send_pat(s.is_abort ? 8'b0111_1111 : 8'b0111_1110);
    for (int i = 1; i <= 6; i++) begin
      if (s.is_abort) Rx_AbortDetect = (i == s.det_delay);
      else            Rx_FlagDetect  = (i == s.det_delay);
      tick();
    end
    Rx_AbortDetect = 1'b0;
    Rx_FlagDetect  = 1'b0;
    repeat (2) tick();
    check($sformatf("scen%0d_vec", idx), 32'(ErrVec), 32'(s.exp_vec));
    check($sformatf("scen%0d_cnt", idx), 32'(ErrCnt), 32'(s.exp_cnt));
    check($sformatf("scen%0d_pulses", idx), 32'(pulses), 32'(s.exp_pulses));
    MonEn = 1'b1;
  endtask

  scen_t scen [10];

  initial begin
    scen[0] = '{1'b0, 1'b1, 2, 5'b00000, 0, 0};
    scen[1] = '{1'b0, 1'b1, 0, 5'b00001, 1, 1};
    scen[2] = '{1'b0, 1'b1, 1, 5'b00001, 2, 2};
    scen[3] = '{1'b0, 1'b1, 3, 5'b00001, 2, 2};
    scen[4] = '{1'b0, 1'b0, 1, 5'b00000, 0, 0};
    scen[5] = '{1'b1, 1'b1, 2, 5'b00000, 0, 0};
    scen[6] = '{1'b1, 1'b1, 0, 5'b00010, 1, 1};
    scen[7] = '{1'b1, 1'b1, 1, 5'b00010, 1, 1};
    scen[8] = '{1'b1, 1'b1, 3, 5'b00010, 1, 1};
    scen[9] = '{1'b1, 1'b0, 0, 5'b00000, 0, 0};

    Rst = 1'b1; MonEn = 1'b1; ErrClr = 1'b0; Rx = 1'b0;
    Rx_ValidFrame = 1'b0; Rx_FlagDetect = 1'b0; Rx_AbortDetect = 1'b0;
    Rx_AbortSignal = 1'b0; Rx_EoF = 1'b0; Rx_NewByte = 1'b0; Rx_Overflow = 1'b0;
    repeat (3) tick();
    check("rst_vec", 32'(ErrVec), 32'd0);
    check("rst_cnt", 32'(ErrCnt), 32'd0);
    check("rst_frames", 32'(FrameCnt), 32'd0);
    check("rst_pulse", 32'(ErrPulse), 32'd0);
    Rst = 1'b0;
    repeat (10) tick();
    check("post_rst_cnt", 32'(ErrCnt), 32'd0);

    for (int i = 0; i < 10; i++) run_scen(i, scen[i]);

    // Abort signal inside a frame: one good follow-up, one missing.
    clear_errs();
    start_frame();
    repeat (10) tick();
    send_pat(8'b0111_1111);
    tick();
    Rx_AbortDetect = 1'b1; tick(); Rx_AbortDetect = 1'b0;
    Rx_AbortSignal = 1'b1; tick(); Rx_AbortSignal = 1'b0;
    repeat (3) tick();
    Rx_AbortDetect = 1'b1; tick(); Rx_AbortDetect = 1'b0;
    repeat (3) tick();
    end_frame(1'b1);
    repeat (2) tick();
    check("abort_sig_vec", 32'(ErrVec), 32'b00100);
    check("abort_sig_cnt", 32'(ErrCnt), 32'd1);
    check("abort_sig_pulses", 32'(pulses), 32'd1);
    check("abort_sig_frames", 32'(FrameCnt), 32'(frames_exp));

    // End of frame with and without Rx_EoF.
    clear_errs();
    start_frame();
    repeat (5) tick();
    end_frame(1'b1);
    repeat (2) tick();
    check("eof_ok_vec", 32'(ErrVec), 32'd0);
    check("eof_ok_frames", 32'(FrameCnt), 32'(frames_exp));
    start_frame();
    repeat (5) tick();
    end_frame(1'b0);
    repeat (2) tick();
    check("eof_miss_vec", 32'(ErrVec), 32'b01000);
    check("eof_miss_cnt", 32'(ErrCnt), 32'd1);
    check("eof_miss_frames", 32'(FrameCnt), 32'(frames_exp));

    // Nine spurious flag detects saturate the 3-bit counter; clear wins over a violation.
    clear_errs();
    Rx_FlagDetect = 1'b1;
    repeat (9) tick();
    Rx_FlagDetect = 1'b0;
    repeat (2) tick();
    check("sat_cnt_wide", 32'(ErrCnt), 32'd9);
    check("sat_cnt_narrow", 32'(ErrCnt_s), 32'd7);
    check("sat_vec", 32'(ErrVec_s), 32'b00001);
    check("sat_pulses", 32'(pulses), 32'd9);
    Rx_FlagDetect = 1'b1;
    ErrClr = 1'b1;
    tick();
    check("clr_pulse", 32'(ErrPulse_s), 32'd1);
    check("clr_cnt", 32'(ErrCnt), 32'd0);
    check("clr_cnt_narrow", 32'(ErrCnt_s), 32'd0);
    check("clr_vec", 32'(ErrVec), 32'd0);
    Rx_FlagDetect = 1'b0;
    ErrClr = 1'b0;
    tick();
    check("clr_after_cnt", 32'(ErrCnt), 32'd0);

    // Overflow: 128 bytes legal, byte 129 with timely Rx_Overflow legal.
    clear_errs();
    start_frame();
    send_bytes(128);
    repeat (3) tick();
    check("ovf_128_cnt", 32'(ErrCnt), 32'd0);
    send_bytes(1);
    Rx_Overflow = 1'b1; tick(); Rx_Overflow = 1'b0;
    tick();
    end_frame(1'b1);
    repeat (2) tick();
    check("ovf_ok_vec", 32'(ErrVec), 32'd0);
    check("ovf_ok_cnt", 32'(ErrCnt), 32'd0);
    // Early Rx_Overflow after 100 bytes.
    start_frame();
    send_bytes(100);
    Rx_Overflow = 1'b1; tick(); Rx_Overflow = 1'b0;
    tick();
    end_frame(1'b1);
    repeat (2) tick();
    check("ovf_early_vec", 32'(ErrVec), 32'b10000);
    check("ovf_early_cnt", 32'(ErrCnt), 32'd1);
    // Missing Rx_Overflow after byte 129.
    clear_errs();
    start_frame();
    send_bytes(129);
    repeat (3) tick();
    end_frame(1'b1);
    repeat (2) tick();
    check("ovf_miss_vec", 32'(ErrVec), 32'b10000);
    check("ovf_miss_pulses", 32'(pulses), 32'd1);

    // Reset mid-frame after 50 bytes, then a clean 129-byte frame.
    start_frame();
    send_bytes(50);
    Rst = 1'b1;
    Rx_ValidFrame = 1'b0;
    #1;
    check("midrst_vec", 32'(ErrVec), 32'd0);
    check("midrst_cnt", 32'(ErrCnt), 32'd0);
    check("midrst_frames", 32'(FrameCnt), 32'd0);
    check("midrst_frames_narrow", 32'(FrameCnt_s), 32'd0);
    frames_exp = 0;
    repeat (2) tick();
    Rst = 1'b0;
    pulses = 0;
    repeat (10) tick();
    start_frame();
    send_bytes(128);
    repeat (2) tick();
    check("newframe_128_cnt", 32'(ErrCnt), 32'd0);
    send_bytes(1);
    Rx_Overflow = 1'b1; tick(); Rx_Overflow = 1'b0;
    tick();
    end_frame(1'b1);
    repeat (2) tick();
    check("newframe_vec", 32'(ErrVec), 32'd0);
    check("newframe_cnt", 32'(ErrCnt), 32'd0);
    check("newframe_pulses", 32'(pulses), 32'd0);
    check("newframe_frames", 32'(FrameCnt), 32'(frames_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
